hash_round_ctrl: RTL
====================

Name: hash_round_ctrl

Overview:
Parametrised round sequencer for the iterative hash cores (SHA-1 80 rounds, SHA-256/MD5 64 rounds).
- Accepts message blocks over a valid/ready handshake.
- Chains multi-block messages and sequences LOAD/ROUND/FINAL phases.
- Emits the round index t, and presents the digest over an output valid/ready handshake.
- Sits between the padding/block-buffer front end and the round datapath; it drives the datapath's load/enable/final-add strobes.

Parameters:
ROUNDS   80   rounds per block (legal 2..2**T_W)
T_W      8    width of round index t
BLK_W    16   width of block counter; saturates at all-ones

Ports:
clk        in   1      clock
rst_n      in   1      synchronous active-low reset
in_valid   in   1      block available from front end
in_last    in   1      block is last of message; sampled on accept
in_ready   out  1      controller can accept a block
clear      in   1      synchronous abort to IDLE
load       out  1      datapath: load block/working vars this cycle
init       out  1      with load: use IV (first block) instead of chained digest
round_en   out  1      datapath: execute round t this cycle
t          out  T_W    round index, 0 outside ROUND
final_add  out  1      datapath: add working vars into digest this cycle
out_valid  out  1      digest valid
out_ready  in   1      consumer takes digest
blk_cnt    out  BLK_W  blocks processed in current message
busy       out  1      state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-low on `rst_n`.
- Reset, sampled at a `clk` edge with `rst_n`=0:
  - state=IDLE, t=0, blk_cnt=0, first flag=1, last_q=0.
  - All strobes and out_valid are 0.
  - Overrides everything, including mid-round.
- States: IDLE, LOAD, ROUND, FINAL, NEXT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: capture last_q<=in_last, go to LOAD.
- LOAD (1 cycle):
  - load=1, init=first flag.
  - Clear first flag; go to ROUND with t=0.
- ROUND:
  - round_en=1; t increments by 1 each cycle.
  - When t==ROUNDS-1: t<=0, go to FINAL.
  - Exactly ROUNDS round_en cycles per block.
- FINAL (1 cycle):
  - final_add=1; blk_cnt increments, saturating.
  - last_q=1 goes to DONE; otherwise goes to NEXT.
- NEXT:
  - in_ready=1; digest is held chained.
  - Accept goes to LOAD with init=0.
  - in_valid low: wait indefinitely.
- DONE:
  - out_valid=1, held until out_ready.
  - out_valid&out_ready: go to IDLE, set first flag=1, blk_cnt<=0.
  - out_valid never drops without a handshake.
- in_ready is 0 in LOAD, ROUND, FINAL and DONE. No new message is accepted while the digest is unconsumed.
- Latency, single block, accept in cycle 0:
  - load in cycle 1.
  - round_en in cycles 2..ROUNDS+1.
  - final_add in cycle ROUNDS+2.
  - out_valid from cycle ROUNDS+3.
- Back-to-back blocks: NEXT accept in cycle c gives load in cycle c+1. Throughput is ROUNDS+3 cycles per block when in_valid is held high.
- clear:
  - Next state is IDLE, t=0, first flag=1, blk_cnt=0; any pending out_valid is dropped.
  - A clear and an accept in the same cycle: clear wins; the block is not accepted.
- Outputs are registered or decoded from registered state only; there is no combinational path from in_valid/out_ready to any output except through state.
- t arithmetic is modulo 2**T_W, but wrap cannot occur because ROUNDS<=2**T_W.

Optional Feature:
Macro HASH_ROUND_STALL_EN.
- Defined:
  - Adds input port `stall` (1 bit).
  - In ROUND with stall=1: round_en=0 and t holds; the state machine does not advance.
  - In LOAD/FINAL, stall is ignored.
  - clear and reset still override stall.
- Undefined: the port is absent; ROUND always advances every cycle.

Decomposition:
- Package hash_pkg:
  - state enum (IDLE, LOAD, ROUND, FINAL, NEXT, DONE).
  - Round constants SHA1_ROUNDS=80, SHA256_ROUNDS=64, MD5_ROUNDS=64.
  - Default T_W=8.
- One sub-module hash_round_cnt:
  - T_W-bit counter with inputs clr, en, and terminal value.
  - Output tc = (cnt==ROUNDS-1)&en.
  - Instantiated once for t.

Test Plan:
1. Single block, ROUNDS=80: in_valid=1, in_last=1 in cycle 0 -> load=1 & init=1 in cycle 1; round_en cycles 2..81 with t=0..79; final_add cycle 82; out_valid cycle 83; blk_cnt=1.
2. Three-block message, in_valid held: -> three load pulses spaced 83 cycles apart, init=1 only on the first; out_valid after the third FINAL; blk_cnt=3; in_ready=1 only in IDLE/NEXT.
3. out_ready held 0 for 10 cycles in DONE -> out_valid stays 1 and in_ready=0; out_ready=1 -> IDLE next cycle, blk_cnt=0.
4. rst_n=0 at t=40 mid-round -> next edge: state IDLE, t=0, busy=0, all strobes 0. clear=1 at t=40 gives the same result, and clear with a simultaneous in_valid is not accepted.
5. ROUNDS=64, T_W=6 -> t sequences 0..63, no wrap glitch, exactly 64 round_en cycles.
6. HASH_ROUND_STALL_EN defined, stall=1 for 5 cycles at t=10 -> t holds at 10 with round_en=0; total ROUND duration is 85 cycles, and out_valid arrives 5 cycles later than in scenario 1.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types and constants for the iterative hash round controller.
package hash_pkg;

  localparam int unsigned SHA1_ROUNDS   = 80;
  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned MD5_ROUNDS    = 64;
  localparam int unsigned DEF_T_W       = 8;
  localparam int unsigned DEF_BLK_W     = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hash_round_cnt.sv
// Round index counter: counts while en, wraps to 0 after the terminal value.
module hash_round_cnt
  import hash_pkg::*;
#(
  parameter int unsigned T_W = DEF_T_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [T_W-1:0] term,
  output logic [T_W-1:0] cnt,
  output logic           tc
);

  logic [T_W-1:0] r_cnt;

  assign tc  = (r_cnt == term) & en;
  assign cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (tc) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + T_W'(1);
    end
  end

endmodule

// File: rtl/hash_round_ctrl.sv
// Block sequencer for iterative hash cores: LOAD / ROUND x N / FINAL per block.
// Optional macro HASH_ROUND_STALL_EN adds a stall input that freezes ROUND.
module hash_round_ctrl
  import hash_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA1_ROUNDS,
  parameter int unsigned T_W    = DEF_T_W,
  parameter int unsigned BLK_W  = DEF_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef HASH_ROUND_STALL_EN
  input  logic             stall,
`endif
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clear,
  output logic             load,
  output logic             init,
  output logic             round_en,
  output logic [T_W-1:0]   t,
  output logic             final_add,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] blk_cnt,
  output logic             busy
);

  state_t           r_state;
  logic             r_first;
  logic             r_last_q;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_load;
  logic             r_init;
  logic             r_round_act;
  logic             r_final_add;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;
  logic             w_en;
  logic             w_tc;
  logic [T_W-1:0]   w_t;

`ifdef HASH_ROUND_STALL_EN
  assign w_en = r_round_act & ~stall;
`else
  assign w_en = r_round_act;
`endif

  hash_round_cnt #(.T_W(T_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (w_en),
    .term  (T_W'(ROUNDS - 1)),
    .cnt   (w_t),
    .tc    (w_tc)
  );

  assign in_ready  = r_in_ready;
  assign load      = r_load;
  assign init      = r_init;
  assign round_en  = w_en;
  assign t         = w_t;
  assign final_add = r_final_add;
  assign out_valid = r_out_valid;
  assign blk_cnt   = r_blk_cnt;
  assign busy      = r_busy;

  // Strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_first     <= 1'b1;
      r_last_q    <= 1'b0;
      r_blk_cnt   <= '0;
      r_load      <= 1'b0;
      r_init      <= 1'b0;
      r_round_act <= 1'b0;
      r_final_add <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_init      <= 1'b0;
      r_final_add <= 1'b0;
      if (clear) begin
        r_state     <= IDLE;
        r_first     <= 1'b1;
        r_blk_cnt   <= '0;
        r_round_act <= 1'b0;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE, NEXT: begin
            if (in_valid) begin
              r_last_q   <= in_last;
              r_state    <= LOAD;
              r_load     <= 1'b1;
              r_init     <= r_first;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
          LOAD: begin
            r_first     <= 1'b0;
            r_state     <= ROUND;
            r_round_act <= 1'b1;
          end
          ROUND: begin
            if (w_tc) begin
              r_state     <= FINAL;
              r_round_act <= 1'b0;
              r_final_add <= 1'b1;
            end
          end
          FINAL: begin
            if (r_blk_cnt != '1) begin
              r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end
            if (r_last_q) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= NEXT;
              r_in_ready <= 1'b1;
            end
          end
          DONE: begin
            if (out_ready) begin
              r_state     <= IDLE;
              r_first     <= 1'b1;
              r_blk_cnt   <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
